// File: rtl/bootprom_ctrl.sv
// bootprom_ctrl: sequences a 27256 EPROM pair for 16-bit CPU reads with a post-reset boot overlay
module bootprom_ctrl #(
  parameter int WAIT_STATES = 3,
  parameter int BOOT_READS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_sel,
  input  logic        cpu_rw,
  input  logic [14:0] cpu_addr,
  output logic [15:0] cpu_data,
  output logic        cpu_ack,
  output logic        cpu_berr,
  output logic [14:0] prom_addr,
  output logic        prom_ce_n,
  output logic        prom_oe_n,
  input  logic [7:0]  prom_data_h,
  input  logic [7:0]  prom_data_l,
  output logic        boot_overlay
);
  localparam int CW = BOOT_READS > 0 ? $clog2(BOOT_READS + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(BOOT_READS > 0 ? BOOT_READS - 1 : 0);
  localparam logic [3:0] WLAST = 4'(WAIT_STATES - 1);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, LATCH, ACK, WREL, ERR} state_t;
  state_t state, nxt;
  logic [3:0] wcnt;
  logic [CW-1:0] cnt;
  logic hit;
  assign hit = cpu_req & (cpu_sel | boot_overlay);
  // next state; dropping cpu_req mid-access aborts back to IDLE without an ack
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = hit ? (cpu_rw ? SETUP : ERR) : IDLE;
      SETUP:   nxt = cpu_req ? ACCESS : IDLE;
      ACCESS:  nxt = !cpu_req ? IDLE : (wcnt == WLAST ? LATCH : ACCESS);
      LATCH:   nxt = cpu_req ? ACK : IDLE;
      ACK:     nxt = WREL;
      WREL:    nxt = cpu_req ? WREL : IDLE;
      ERR:     nxt = cpu_req ? ERR : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // state register; outputs are registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wcnt         <= '0;
      cnt          <= '0;
      boot_overlay <= (BOOT_READS != 0);
      cpu_data     <= '0;
      cpu_ack      <= 1'b0;
      cpu_berr     <= 1'b0;
      prom_addr    <= '0;
      prom_ce_n    <= 1'b1;
      prom_oe_n    <= 1'b1;
    end else begin
      state     <= nxt;
      wcnt      <= (state == ACCESS) ? wcnt + 4'd1 : 4'd0;
      prom_ce_n <= !(nxt inside {SETUP, ACCESS, LATCH});
      prom_oe_n <= !(nxt inside {ACCESS, LATCH});
      cpu_ack   <= (nxt == ACK);
      cpu_berr  <= (nxt == ERR);
      if (state == IDLE && nxt == SETUP) prom_addr <= cpu_addr;
      if (state == LATCH && nxt == ACK) cpu_data <= {prom_data_h, prom_data_l};
      if (state == ACK && boot_overlay) begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST) boot_overlay <= 1'b0;
      end
    end
  end
endmodule
